// File: rtl/spi_cfg_engine.sv
// Table-driven SPI register configurator: walks NUM_REGS {addr, data} entries,
// writes each as one mode-0 SPI frame and optionally reads it back to verify.
module spi_cfg_engine #(
   parameter int ADDR_W   = 13,
   parameter int DATA_W   = 8,
   parameter int NUM_REGS = 64,
   parameter int CLK_DIV  = 4,
   parameter int CS_GAP   = 4,
   parameter int VERIFY   = 0,
   localparam int IDX_W   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   output logic                     busy,
   output logic                     done,
   output logic                     err,
   output logic [IDX_W-1:0]         err_idx,
   output logic [IDX_W-1:0]         tbl_idx,
   input  logic [ADDR_W+DATA_W-1:0] tbl_entry,
   output logic                     spi_clk,
   output logic                     cs,
   output logic                     spi_mosi,
   input  logic                     spi_miso
);

   localparam int FRAME_W = ADDR_W + 3 + DATA_W;
   localparam int CNT_MAX = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam int BIT_W   = $clog2(FRAME_W);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_LOAD,
      S_SHIFT,
      S_GAP,
      S_NEXT,
      S_DONE
   } state_e;

   state_e              state_q,    state_d;
   logic [IDX_W-1:0]    idx_q,      idx_d;
   logic                err_q,      err_d;
   logic [IDX_W-1:0]    err_idx_q,  err_idx_d;
   logic [ADDR_W-1:0]   addr_q,     addr_d;
   logic [DATA_W-1:0]   data_q,     data_d;
   logic                rd_phase_q, rd_phase_d;
   logic [FRAME_W-1:0]  tx_q,       tx_d;
   logic [DATA_W-1:0]   rx_q,       rx_d;
   logic [CNT_W-1:0]    cnt_q,      cnt_d;
   logic [BIT_W-1:0]    bit_q,      bit_d;
   logic                spi_clk_q,  spi_clk_d;
   logic                cs_q,       cs_d;
   logic                mosi_q,     mosi_d;

   always_comb begin
      // NOTE: every _d starts as its _q so no branch can leave a signal unassigned and infer a latch.
      state_d    = state_q;
      idx_d      = idx_q;
      err_d      = err_q;
      err_idx_d  = err_idx_q;
      addr_d     = addr_q;
      data_d     = data_q;
      rd_phase_d = rd_phase_q;
      tx_d       = tx_q;
      rx_d       = rx_q;
      cnt_d      = cnt_q;
      bit_d      = bit_q;
      spi_clk_d  = spi_clk_q;
      cs_d       = cs_q;
      mosi_d     = mosi_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               idx_d      = '0;
               err_d      = 1'b0;
               err_idx_d  = '0;
               rd_phase_d = 1'b0;
               state_d    = S_FETCH;
            end
         end

         S_FETCH: state_d = S_LOAD;

         S_LOAD: begin
            // The read-back frame reuses the address and expected data of the write.
            if (!rd_phase_q) begin
               addr_d = tbl_entry[ADDR_W+DATA_W-1:DATA_W];
               data_d = tbl_entry[DATA_W-1:0];
            end
            tx_d      = {rd_phase_q, 2'b00, addr_d, (rd_phase_q ? {DATA_W{1'b0}} : data_d)};
            mosi_d    = tx_d[FRAME_W-1];
            cs_d      = 1'b0;
            spi_clk_d = 1'b0;
            cnt_d     = '0;
            bit_d     = '0;
            state_d   = S_SHIFT;
         end

         S_SHIFT: begin
            if (cnt_q == CNT_W'(CLK_DIV - 1)) begin
               cnt_d     = '0;
               spi_clk_d = ~spi_clk_q;
               if (!spi_clk_q) begin
                  rx_d = DATA_W'({rx_q, spi_miso});
               end else if (bit_q == BIT_W'(FRAME_W - 1)) begin
                  cs_d    = 1'b1;
                  mosi_d  = 1'b0;
                  state_d = S_GAP;
               end else begin
                  bit_d  = bit_q + 1'b1;
                  tx_d   = tx_q << 1;
                  mosi_d = tx_q[FRAME_W-2];
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         S_GAP: begin
            if (cnt_q == CNT_W'(CS_GAP - 1)) begin
               cnt_d = '0;
               if ((VERIFY != 0) && !rd_phase_q) begin
                  rd_phase_d = 1'b1;
                  state_d    = S_LOAD;
               end else begin
                  state_d = S_NEXT;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         S_NEXT: begin
            // Only the first mismatch is recorded; later ones leave err_idx alone.
            if ((VERIFY != 0) && (rx_q != data_q) && !err_q) begin
               err_d     = 1'b1;
               err_idx_d = idx_q;
            end
            rd_phase_d = 1'b0;
            if (idx_q == IDX_W'(NUM_REGS - 1)) begin
               state_d = S_DONE;
            end else begin
               idx_d   = idx_q + 1'b1;
               state_d = S_FETCH;
            end
         end

         S_DONE: state_d = S_IDLE;

         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: the whole datapath is reset too, so an aborted frame leaves nothing behind to resume.
      if (rst) begin
         state_q    <= S_IDLE;
         idx_q      <= '0;
         err_q      <= 1'b0;
         err_idx_q  <= '0;
         addr_q     <= '0;
         data_q     <= '0;
         rd_phase_q <= 1'b0;
         tx_q       <= '0;
         rx_q       <= '0;
         cnt_q      <= '0;
         bit_q      <= '0;
         spi_clk_q  <= 1'b0;
         cs_q       <= 1'b1;
         mosi_q     <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments keep every register updating from pre-edge values.
         state_q    <= state_d;
         idx_q      <= idx_d;
         err_q      <= err_d;
         err_idx_q  <= err_idx_d;
         addr_q     <= addr_d;
         data_q     <= data_d;
         rd_phase_q <= rd_phase_d;
         tx_q       <= tx_d;
         rx_q       <= rx_d;
         cnt_q      <= cnt_d;
         bit_q      <= bit_d;
         spi_clk_q  <= spi_clk_d;
         cs_q       <= cs_d;
         mosi_q     <= mosi_d;
      end
   end

   // done overlaps the last busy cycle, so a start coinciding with done is ignored.
   assign busy     = (state_q != S_IDLE);
   assign done     = (state_q == S_DONE);
   assign err      = err_q;
   assign err_idx  = err_idx_q;
   assign tbl_idx  = idx_q;
   assign spi_clk  = spi_clk_q;
   assign cs       = cs_q;
   assign spi_mosi = mosi_q;

endmodule

// File: tb/tb_spi_cfg_engine.sv
// Bench for spi_cfg_engine: three instances (write-only, verify, fast divider)
// share one SPI slave model with a register file and optional readback corruption.
module tb_spi_cfg_engine;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic        start_a = 1'b0, start_v = 1'b0, start_f = 1'b0;
   logic        busy_a, busy_v, busy_f, done_a, done_v, done_f, err_a, err_v, err_f;
   logic [1:0]  err_idx_a, err_idx_v, tbl_idx_a, tbl_idx_v;
   logic [0:0]  err_idx_f, tbl_idx_f;
   logic [20:0] ent_a, ent_v, ent_f;
   logic        sck_a, sck_v, sck_f, cs_a, cs_v, cs_f, mosi_a, mosi_v, mosi_f;
   logic        spi_miso;

   spi_cfg_engine #(.NUM_REGS(3), .CLK_DIV(2), .CS_GAP(4), .VERIFY(0)) u_dut_a (
      .clk(clk), .rst(rst), .start(start_a), .busy(busy_a), .done(done_a), .err(err_a),
      .err_idx(err_idx_a), .tbl_idx(tbl_idx_a), .tbl_entry(ent_a), .spi_clk(sck_a),
      .cs(cs_a), .spi_mosi(mosi_a), .spi_miso(spi_miso));

   spi_cfg_engine #(.NUM_REGS(3), .CLK_DIV(2), .CS_GAP(4), .VERIFY(1)) u_dut_v (
      .clk(clk), .rst(rst), .start(start_v), .busy(busy_v), .done(done_v), .err(err_v),
      .err_idx(err_idx_v), .tbl_idx(tbl_idx_v), .tbl_entry(ent_v), .spi_clk(sck_v),
      .cs(cs_v), .spi_mosi(mosi_v), .spi_miso(spi_miso));

   spi_cfg_engine #(.NUM_REGS(1), .CLK_DIV(1), .CS_GAP(1), .VERIFY(0)) u_dut_f (
      .clk(clk), .rst(rst), .start(start_f), .busy(busy_f), .done(done_f), .err(err_f),
      .err_idx(err_idx_f), .tbl_idx(tbl_idx_f), .tbl_entry(ent_f), .spi_clk(sck_f),
      .cs(cs_f), .spi_mosi(mosi_f), .spi_miso(spi_miso));

   // Idle instances hold cs=1, spi_clk=0, mosi=0, so the bus can be merged.
   logic cs_m, sck_m, mosi_m;
   assign cs_m   = cs_a & cs_v & cs_f;
   assign sck_m  = sck_a | sck_v | sck_f;
   assign mosi_m = mosi_a | mosi_v | mosi_f;

   // Configuration table with one cycle of lookup latency.
   logic [20:0] tbl_mem [4] = '{{13'h0001, 8'hAB}, {13'h00C8, 8'h55}, {13'h1FFF, 8'hFF}, 21'h0};
   always @(posedge clk) begin
      ent_a <= tbl_mem[tbl_idx_a];
      ent_v <= tbl_mem[tbl_idx_v];
      ent_f <= tbl_mem[tbl_idx_f];
   end

   logic [23:0] fr_wr  [3] = '{24'h0001AB, 24'h00C855, 24'h1FFFFF};
   logic [23:0] fr_vfy [6] = '{24'h0001AB, 24'h800100, 24'h00C855, 24'h80C800, 24'h1FFFFF, 24'h9FFF00};

   // ---------------- SPI slave model ----------------
   typedef struct {
      logic [23:0] val;
      int          low;
      int          first_rise;
      int          period;
   } frame_rec_t;

   frame_rec_t  frames [$];
   logic [7:0]  mem [8192];
   bit          corrupt = 1'b0;
   logic [23:0] sh = '0;
   int          nb = 0, low_cnt = 0, first_rise = 0, period = 0, last_rise = 0;
   logic [7:0]  rd_val = '0;

   function automatic logic [7:0] readback(input logic [12:0] a);
      if (corrupt && a == 13'h00C8) return 8'h54;
      if (corrupt && a == 13'h1FFF) return 8'h00;
      return mem[a];
   endfunction

   always @(negedge clk) begin
      if (cs_m !== 1'b0) low_cnt <= 0;
      else low_cnt <= low_cnt + 1;
   end

   always @(posedge sck_m or negedge cs_m) begin
      if (sck_m === 1'b1) begin
         sh <= {sh[22:0], mosi_m};
         nb <= nb + 1;
         if (nb == 0) first_rise <= low_cnt;
         else period <= low_cnt - last_rise;
         last_rise <= low_cnt;
         if (nb == 15) rd_val <= sh[14] ? readback({sh[11:0], mosi_m}) : 8'h00;
      end else begin
         nb <= 0;
      end
   end

   assign spi_miso = (cs_m === 1'b0 && nb >= 16 && nb < 24) ? rd_val[23-nb] : 1'b0;

   always @(posedge cs_m) begin
      if (nb == 24) begin
         frames.push_back('{val: sh, low: low_cnt, first_rise: first_rise, period: period});
         if (!sh[23]) mem[sh[20:8]] <= sh[7:0];
      end
   end

   // ---------------- checking ----------------
   int checks = 0;
   int failures = 0;
   int sel = 0;
   logic cur_busy, cur_done, cur_err;
   int   cur_err_idx, cur_tbl_idx;

   always_comb begin
      cur_busy = busy_a; cur_done = done_a; cur_err = err_a;
      cur_err_idx = int'(err_idx_a); cur_tbl_idx = int'(tbl_idx_a);
      if (sel == 1) begin
         cur_busy = busy_v; cur_done = done_v; cur_err = err_v;
         cur_err_idx = int'(err_idx_v); cur_tbl_idx = int'(tbl_idx_v);
      end else if (sel == 2) begin
         cur_busy = busy_f; cur_done = done_f; cur_err = err_f;
         cur_err_idx = int'(err_idx_f); cur_tbl_idx = int'(tbl_idx_f);
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive_start(input int s, input logic v);
      case (s)
         0: start_a = v;
         1: start_v = v;
         default: start_f = v;
      endcase
   endtask

   typedef struct {
      int sel;      // 0 write-only, 1 verify, 2 fast divider
      bit corrupt;  // slave corrupts readback of entries 1 and 2
      bit extra;    // stray start at cycle 50 and at the done cycle
      int nfr;      // expected frame count
      int cd;       // CLK_DIV of the instance
      bit exp_err;
      int exp_err_idx;
      int exp_cyc;  // clock edges from start acceptance to done
   } vec_t;

   task automatic run_vec(input vec_t v, input int vi);
      int  n;
      bit  seen;
      logic [23:0] exp_fr;
      sel = v.sel;
      corrupt = v.corrupt;
      frames.delete();
      @(negedge clk);
      drive_start(v.sel, 1'b1);
      @(posedge clk); #1;
      drive_start(v.sel, 1'b0);
      check($sformatf("v%0d busy_after_start", vi), cur_busy, 1);
      check($sformatf("v%0d tbl_idx_start", vi), cur_tbl_idx, 0);
      check($sformatf("v%0d err_cleared", vi), cur_err, 0);
      n = 0;
      seen = 1'b0;
      while (!seen && n < 2000) begin
         if (v.extra && n == 50) drive_start(v.sel, 1'b1);
         else if (v.extra && n == 51) drive_start(v.sel, 1'b0);
         @(posedge clk); n++; #1;
         seen = cur_done;
      end
      check($sformatf("v%0d done_seen", vi), seen, 1);
      check($sformatf("v%0d done_cycle", vi), n, v.exp_cyc);
      check($sformatf("v%0d busy_at_done", vi), cur_busy, 1);
      if (v.extra) drive_start(v.sel, 1'b1);
      @(posedge clk); #1;
      drive_start(v.sel, 1'b0);
      check($sformatf("v%0d done_one_cycle", vi), cur_done, 0);
      check($sformatf("v%0d busy_after_done", vi), cur_busy, 0);
      check($sformatf("v%0d frame_count", vi), frames.size(), v.nfr);
      for (int k = 0; k < v.nfr && k < frames.size(); k++) begin
         exp_fr = (v.sel == 1) ? fr_vfy[k] : fr_wr[k];
         check($sformatf("v%0d frame%0d", vi, k), frames[k].val, exp_fr);
         check($sformatf("v%0d cs_low%0d", vi, k), frames[k].low, 2 * v.cd * 24);
      end
      if (frames.size() > 0) begin
         check($sformatf("v%0d first_rise", vi), frames[0].first_rise, v.cd);
         check($sformatf("v%0d sck_period", vi), frames[0].period, 2 * v.cd);
      end
      check($sformatf("v%0d err", vi), cur_err, v.exp_err);
      check($sformatf("v%0d err_idx", vi), cur_err_idx, v.exp_err_idx);
   endtask

   vec_t vecs [6];
   int   lows;

   initial begin
      vecs[0] = '{sel:0, corrupt:0, extra:0, nfr:3, cd:2, exp_err:0, exp_err_idx:0, exp_cyc:309};
      vecs[1] = '{sel:0, corrupt:0, extra:1, nfr:3, cd:2, exp_err:0, exp_err_idx:0, exp_cyc:309};
      vecs[2] = '{sel:1, corrupt:0, extra:0, nfr:6, cd:2, exp_err:0, exp_err_idx:0, exp_cyc:612};
      vecs[3] = '{sel:1, corrupt:1, extra:0, nfr:6, cd:2, exp_err:1, exp_err_idx:1, exp_cyc:612};
      vecs[4] = '{sel:1, corrupt:0, extra:0, nfr:6, cd:2, exp_err:0, exp_err_idx:0, exp_cyc:612};
      vecs[5] = '{sel:2, corrupt:0, extra:0, nfr:1, cd:1, exp_err:0, exp_err_idx:0, exp_cyc:52};

      // Reset state.
      repeat (3) @(posedge clk);
      #1;
      check("rst_cs", cs_m, 1);
      check("rst_spi_clk", sck_m, 0);
      check("rst_mosi", mosi_m, 0);
      check("rst_busy", busy_a, 0);
      check("rst_done", done_a, 0);
      check("rst_err", err_a, 0);
      check("rst_err_idx", err_idx_a, 0);
      check("rst_tbl_idx", tbl_idx_a, 0);
      rst = 1'b0;

      // Reset in the middle of the second frame aborts it for good.
      sel = 0;
      @(negedge clk);
      drive_start(0, 1'b1);
      @(posedge clk); #1;
      drive_start(0, 1'b0);
      repeat (150) @(posedge clk);
      #1;
      check("mid_frame2_cs_low", cs_m, 0);
      rst = 1'b1;
      @(posedge clk); #1;
      check("abort_cs", cs_m, 1);
      check("abort_spi_clk", sck_m, 0);
      check("abort_busy", busy_a, 0);
      check("abort_tbl_idx", tbl_idx_a, 0);
      rst = 1'b0;
      lows = 0;
      repeat (10) begin
         @(posedge clk); #1;
         if (cs_m !== 1'b1 || busy_a !== 1'b0) lows++;
      end
      check("abort_no_resume", lows, 0);

      for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
